// File: rtl/uart_pkg.sv
// Shared types and constants for the UART register-bank AXI-Lite bridge.
// Holds the bridge FSM states, the AXI response codes and the default register count.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        WR_RESP,
        RD_EXEC,
        RD_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int NUM_REGS_DEFAULT = 8;

    // A word index is mapped when it falls below the implemented register count.
    function automatic logic is_mapped(input logic [3:0] idx, input int num_regs);
        return $unsigned(num_regs) > {28'd0, idx};
    endfunction

endpackage

// File: rtl/uart_axil_bridge_if.sv
// AXI-Lite slave port bundle for the UART register bridge.
// The master modport is the bus side, the slave modport is the bridge side.
interface uart_axil_bridge_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, output s_awready,
        input  s_wdata, s_wstrb, s_wvalid, output s_wready,
        output s_bresp, s_bvalid, input  s_bready,
        input  s_araddr, s_arvalid, output s_arready,
        output s_rdata, s_rresp, s_rvalid, input  s_rready
    );

    modport master (
        output s_awaddr, s_awvalid, input  s_awready,
        output s_wdata, s_wstrb, s_wvalid, input  s_wready,
        input  s_bresp, s_bvalid, output s_bready,
        output s_araddr, s_arvalid, input  s_arready,
        input  s_rdata, s_rresp, s_rvalid, output s_rready
    );

endinterface

// File: rtl/uart_axil_bridge.sv
// AXI-Lite slave that turns single-beat reads/writes into register strobes.
// One transaction in flight; writes win over a simultaneous read.
module uart_axil_bridge
    import uart_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    uart_axil_bridge_if.slave   s_axil,
    output logic                reg_write,
    output logic                reg_read,
    output logic [3:0]          reg_addr,
    output logic [31:0]         reg_wdata,
    input  logic [31:0]         reg_rdata,
    input  logic                reg_ready
);

    state_t      r_state;
    logic        r_aw_held;
    logic        r_w_held;
    logic [3:0]  r_aw_idx;
    logic [31:0] r_wdata;
    logic        r_wstrb_ok;
    logic        r_err;
    logic        r_reg_write;
    logic        r_reg_read;
    logic [3:0]  r_reg_addr;
    logic [31:0] r_reg_wdata;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    logic [ADDR_W-1:0] w_awaddr;
    logic [ADDR_W-1:0] w_araddr;
    logic              w_unused_addr;
    logic              w_idle;
    logic              w_awready;
    logic              w_wready;
    logic              w_arready;
    logic              w_aw_fire;
    logic              w_w_fire;
    logic              w_ar_fire;
    logic [3:0]        w_wr_idx;
    logic [31:0]       w_wr_data;
    logic              w_wr_strb_ok;
    logic              w_wr_go;
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign w_awaddr      = s_axil.s_awaddr;
    assign w_araddr      = s_axil.s_araddr;
    // Byte-lane bits and any bits above the word index carry no meaning here.
    assign w_unused_addr = ^{w_awaddr, w_araddr};

    assign w_idle    = (r_state == IDLE);
    assign w_awready = w_idle && !r_aw_held && !reset;
    assign w_wready  = w_idle && !r_w_held && !reset;
    assign w_arready = w_idle && !r_aw_held && !r_w_held
                       && !s_axil.s_awvalid && !s_axil.s_wvalid && !reset;

    assign w_aw_fire = s_axil.s_awvalid && w_awready;
    assign w_w_fire  = s_axil.s_wvalid && w_wready;
    assign w_ar_fire = s_axil.s_arvalid && w_arready;

    // Merge what is already held with what arrives this cycle so the pair
    // completing on either channel launches the write immediately.
    assign w_wr_idx     = r_aw_held ? r_aw_idx : w_awaddr[5:2];
    assign w_wr_data    = r_w_held ? r_wdata : s_axil.s_wdata;
    assign w_wr_strb_ok = r_w_held ? r_wstrb_ok : (s_axil.s_wstrb == 4'hF);
    assign w_wr_go      = (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);
    assign w_wr_ok      = w_wr_strb_ok && is_mapped(w_wr_idx, NUM_REGS);
    assign w_rd_ok      = is_mapped(w_araddr[5:2], NUM_REGS);

    // NOTE: capture/data registers are left out of reset; only control and
    // visible response state is cleared, since nothing reads the rest until rewritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_err       <= 1'b0;
            r_reg_write <= 1'b0;
            r_reg_read  <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_rvalid    <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_aw_fire) begin
                        r_aw_held <= 1'b1;
                        r_aw_idx  <= w_awaddr[5:2];
                    end
                    if (w_w_fire) begin
                        r_w_held   <= 1'b1;
                        r_wdata    <= s_axil.s_wdata;
                        r_wstrb_ok <= (s_axil.s_wstrb == 4'hF);
                    end
                    if (w_wr_go) begin
                        r_state     <= WR_EXEC;
                        r_reg_write <= w_wr_ok;
                        r_reg_addr  <= w_wr_idx;
                        r_reg_wdata <= w_wr_data;
                        r_err       <= !w_wr_ok;
                    end else if (w_ar_fire) begin
                        r_state    <= RD_EXEC;
                        r_reg_read <= w_rd_ok;
                        r_reg_addr <= w_araddr[5:2];
                        r_err      <= !w_rd_ok;
                    end
                end
                WR_EXEC: begin
                    // Errored writes spend one cycle here with no strobe.
                    if (!r_reg_write || reg_ready) begin
                        r_reg_write <= 1'b0;
                        r_bvalid    <= 1'b1;
                        r_bresp     <= r_err ? RESP_SLVERR : RESP_OKAY;
                        r_state     <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axil.s_bready) begin
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                RD_EXEC: begin
                    if (!r_reg_read || reg_ready) begin
                        r_reg_read <= 1'b0;
                        r_rdata    <= r_err ? 32'd0 : reg_rdata;
                        r_rresp    <= r_err ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid   <= 1'b1;
                        r_state    <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (s_axil.s_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_axil.s_awready = w_awready;
    assign s_axil.s_wready  = w_wready;
    assign s_axil.s_arready = w_arready;
    assign s_axil.s_bvalid  = r_bvalid;
    assign s_axil.s_bresp   = r_bresp;
    assign s_axil.s_rvalid  = r_rvalid;
    assign s_axil.s_rresp   = r_rresp;
    assign s_axil.s_rdata   = r_rdata;

    assign reg_write = r_reg_write;
    assign reg_read  = r_reg_read;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;

endmodule

// File: tb/tb_uart_axil_bridge.sv
// Self-checking bench for uart_axil_bridge: directed timing checks plus
// scoreboards for register strobes and AXI responses.
module tb_uart_axil_bridge;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic        reg_read;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ready;
    logic [31:0] rd_value;

    always #5 clk = ~clk;

    uart_axil_bridge_if #(.ADDR_W(6)) axil ();

    uart_axil_bridge #(.ADDR_W(6), .NUM_REGS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_axil    (axil),
        .reg_write (reg_write),
        .reg_read  (reg_read),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready)
    );

    assign reg_rdata = rd_value;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboards: {idx, data} for write strobes, idx for read strobes,
    // bresp for writes, {rresp, rdata} for reads.
    logic [35:0] wr_q[$];
    logic [3:0]  rd_addr_q[$];
    logic [1:0]  bresp_q[$];
    logic [33:0] rd_q[$];

    int cyc = 0;
    int wr_strobes = 0;
    int rd_strobes = 0;
    int wr_high = 0;
    int b_hs = 0;
    int b_hs_cyc = 0;
    int r_hs_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : monitor
        logic [35:0] ew;
        logic [33:0] er;
        if (!reset) begin
            if (reg_write && reg_read) check("strobe_excl", 32'(reg_write & reg_read), 32'd0);
            if (reg_write) wr_high++;
            if (reg_write && reg_ready) begin
                wr_strobes++;
                if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else begin
                    ew = wr_q.pop_front();
                    check("wr_addr", 32'(reg_addr), 32'(ew[35:32]));
                    check("wr_data", reg_wdata, ew[31:0]);
                end
            end
            if (reg_read && reg_ready) begin
                rd_strobes++;
                if (rd_addr_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else check("rd_addr", 32'(reg_addr), 32'(rd_addr_q.pop_front()));
            end
            if (axil.s_bvalid && axil.s_bready) begin
                b_hs++;
                b_hs_cyc = cyc;
                if (bresp_q.size() == 0) check("b_unexpected", 32'd1, 32'd0);
                else check("bresp", 32'(axil.s_bresp), 32'(bresp_q.pop_front()));
            end
            if (axil.s_rvalid && axil.s_rready) begin
                r_hs_cyc = cyc;
                if (rd_q.size() == 0) check("r_unexpected", 32'd1, 32'd0);
                else begin
                    er = rd_q.pop_front();
                    check("rdata", axil.s_rdata, er[31:0]);
                    check("rresp", 32'(axil.s_rresp), 32'(er[33:32]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit exp_strobe, input logic [1:0] resp, input string tag);
        int base;
        int lat;
        base = wr_strobes;
        if (exp_strobe) wr_q.push_back({addr[5:2], data});
        bresp_q.push_back(resp);
        step();
        axil.s_awaddr = addr; axil.s_wdata = data; axil.s_wstrb = strb;
        axil.s_awvalid = 1'b1; axil.s_wvalid = 1'b1;
        @(negedge clk);
        check({tag, "_accept"}, 32'(axil.s_awready & axil.s_wready), 32'd1);
        step();
        axil.s_awvalid = 1'b0; axil.s_wvalid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!axil.s_bvalid && lat < 20) begin
            step(); lat++; @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        step();
        check({tag, "_strobes"}, 32'(wr_strobes - base), 32'(exp_strobe));
    endtask

    task automatic axi_read(input logic [5:0] addr, input bit exp_strobe, input logic [31:0] exp_data,
                            input logic [1:0] resp, input string tag);
        int base;
        int lat;
        base = rd_strobes;
        if (exp_strobe) rd_addr_q.push_back(addr[5:2]);
        rd_q.push_back({resp, exp_data});
        step();
        axil.s_araddr = addr; axil.s_arvalid = 1'b1;
        @(negedge clk);
        check({tag, "_accept"}, 32'(axil.s_arready), 32'd1);
        step();
        axil.s_arvalid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!axil.s_rvalid && lat < 20) begin
            step(); lat++; @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        step();
        check({tag, "_strobes"}, 32'(rd_strobes - base), 32'(exp_strobe));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        int base;
        int hbase;
        int bbase;
        int bad;
        reset = 1'b1; reg_ready = 1'b1; rd_value = '0;
        axil.s_awaddr = '0; axil.s_awvalid = 1'b0; axil.s_wdata = '0; axil.s_wstrb = '0;
        axil.s_wvalid = 1'b0; axil.s_bready = 1'b1; axil.s_araddr = '0; axil.s_arvalid = 1'b0;
        axil.s_rready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_ready", 32'({axil.s_awready, axil.s_wready, axil.s_arready}), 32'd0);
        check("rst_valid", 32'({axil.s_bvalid, axil.s_rvalid, reg_write, reg_read}), 32'd0);
        check("rst_resp", 32'({axil.s_bresp, axil.s_rresp}), 32'd0);
        check("rst_rdata", axil.s_rdata, 32'd0);
        step();
        reset = 1'b0;

        // Single write, AW and W together.
        wr_q.push_back({4'd3, 32'hA5}); bresp_q.push_back(RESP_OKAY);
        step();
        axil.s_awaddr = 6'h0C; axil.s_wdata = 32'hA5; axil.s_wstrb = 4'hF;
        axil.s_awvalid = 1'b1; axil.s_wvalid = 1'b1;
        @(negedge clk);
        check("t1_accept", 32'(axil.s_awready & axil.s_wready), 32'd1);
        step();
        axil.s_awvalid = 1'b0; axil.s_wvalid = 1'b0;
        @(negedge clk);
        check("t1_reg_write_n1", 32'(reg_write), 32'd1);
        check("t1_bvalid_n1", 32'(axil.s_bvalid), 32'd0);
        step();
        @(negedge clk);
        check("t1_bvalid_n2", 32'(axil.s_bvalid), 32'd1);
        check("t1_reg_write_n2", 32'(reg_write), 32'd0);
        step();
        @(negedge clk);
        check("t1_bvalid_clear", 32'(axil.s_bvalid), 32'd0);

        // W at cycle 0, AW at cycle 3.
        base = wr_strobes;
        wr_q.push_back({4'd4, 32'h55}); bresp_q.push_back(RESP_OKAY);
        step();
        axil.s_wdata = 32'h55; axil.s_wstrb = 4'hF; axil.s_wvalid = 1'b1;
        @(negedge clk);
        check("t2_wready_c0", 32'(axil.s_wready), 32'd1);
        step();
        axil.s_wvalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                axil.s_awaddr = 6'h10; axil.s_awvalid = 1'b1;
            end
            @(negedge clk);
            check($sformatf("t2_wready_c%0d", c), 32'(axil.s_wready), 32'd0);
            check($sformatf("t2_reg_write_c%0d", c), 32'(reg_write), 32'd0);
            step();
        end
        axil.s_awvalid = 1'b0;
        @(negedge clk);
        check("t2_reg_write_c4", 32'(reg_write), 32'd1);
        repeat (3) step();
        check("t2_strobes", 32'(wr_strobes - base), 32'd1);

        // Read with rready held low; rdata must be the value seen during RD_EXEC.
        base = rd_strobes;
        rd_value = 32'h1234_5678; axil.s_rready = 1'b0;
        rd_addr_q.push_back(4'd2); rd_q.push_back({RESP_OKAY, 32'h1234_5678});
        step();
        axil.s_araddr = 6'h08; axil.s_arvalid = 1'b1;
        @(negedge clk);
        check("t3_arready", 32'(axil.s_arready), 32'd1);
        step();
        axil.s_arvalid = 1'b0;
        @(negedge clk);
        check("t3_reg_read", 32'(reg_read), 32'd1);
        step();
        rd_value = 32'hFFFF_0000;
        @(negedge clk);
        check("t3_rvalid", 32'(axil.s_rvalid), 32'd1);
        check("t3_rdata", axil.s_rdata, 32'h1234_5678);
        bad = 0;
        repeat (5) begin
            step();
            @(negedge clk);
            if (!axil.s_rvalid || axil.s_rdata !== 32'h1234_5678) bad++;
        end
        check("t3_stable", 32'(bad), 32'd0);
        step();
        axil.s_rready = 1'b1;
        step();
        @(negedge clk);
        check("t3_rvalid_clear", 32'(axil.s_rvalid), 32'd0);
        check("t3_strobes", 32'(rd_strobes - base), 32'd1);

        // Error paths and ignored byte-lane bits.
        axi_write(6'h20, 32'h0000_DEAD, 4'hF, 1'b0, RESP_SLVERR, "t4_wr_unmapped");
        rd_value = 32'hCAFE_F00D;
        axi_read(6'h3C, 1'b0, 32'd0, RESP_SLVERR, "t4_rd_unmapped");
        axi_write(6'h04, 32'h0000_1111, 4'h3, 1'b0, RESP_SLVERR, "t4_wr_strb");
        axi_write(6'h1F, 32'h0BAD_CAFE, 4'hF, 1'b1, RESP_OKAY, "t4_wr_lowbits");
        rd_value = 32'h7777_0001;
        axi_read(6'h1D, 1'b1, 32'h7777_0001, RESP_OKAY, "t4_rd_lowbits");

        // AW, W and AR together: write first, AR held off until after B.
        axil.s_bready = 1'b0; rd_value = 32'h0BAD_F00D;
        wr_q.push_back({4'd5, 32'h77}); bresp_q.push_back(RESP_OKAY);
        rd_addr_q.push_back(4'd6); rd_q.push_back({RESP_OKAY, 32'h0BAD_F00D});
        step();
        axil.s_awaddr = 6'h14; axil.s_wdata = 32'h77; axil.s_wstrb = 4'hF;
        axil.s_araddr = 6'h18; axil.s_awvalid = 1'b1; axil.s_wvalid = 1'b1; axil.s_arvalid = 1'b1;
        @(negedge clk);
        check("t5_arready_c0", 32'(axil.s_arready), 32'd0);
        check("t5_awready_c0", 32'(axil.s_awready), 32'd1);
        step();
        axil.s_awvalid = 1'b0; axil.s_wvalid = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (axil.s_arready) bad++;
            step();
        end
        check("t5_ar_blocked", 32'(bad), 32'd0);
        axil.s_bready = 1'b1;
        @(negedge clk);
        check("t5_arready_bhs", 32'(axil.s_arready), 32'd0);
        step();
        @(negedge clk);
        check("t5_arready_after", 32'(axil.s_arready), 32'd1);
        step();
        axil.s_arvalid = 1'b0;
        bad = 0;
        @(negedge clk);
        while (!axil.s_rvalid && bad < 20) begin
            step(); bad++; @(negedge clk);
        end
        check("t5_rvalid_seen", 32'(axil.s_rvalid), 32'd1);
        step();
        check("t5_order", 32'(r_hs_cyc > b_hs_cyc), 32'd1);

        // reg_ready low for three WR_EXEC cycles.
        base = wr_strobes; hbase = wr_high; bbase = b_hs;
        wr_q.push_back({4'd1, 32'h66}); bresp_q.push_back(RESP_OKAY);
        step();
        axil.s_awaddr = 6'h04; axil.s_wdata = 32'h66; axil.s_wstrb = 4'hF;
        axil.s_awvalid = 1'b1; axil.s_wvalid = 1'b1;
        step();
        axil.s_awvalid = 1'b0; axil.s_wvalid = 1'b0; reg_ready = 1'b0;
        step();
        step();
        step();
        reg_ready = 1'b1;
        @(negedge clk);
        check("t6_reg_write_c4", 32'(reg_write), 32'd1);
        step();
        @(negedge clk);
        check("t6_reg_write_c5", 32'(reg_write), 32'd0);
        check("t6_bvalid_c5", 32'(axil.s_bvalid), 32'd1);
        step();
        step();
        check("t6_write_high", 32'(wr_high - hbase), 32'd4);
        check("t6_strobes", 32'(wr_strobes - base), 32'd1);
        check("t6_bhs", 32'(b_hs - bbase), 32'd1);

        // Reset while in RD_RESP abandons the read.
        axil.s_rready = 1'b0; rd_value = 32'h5A5A_5A5A;
        rd_addr_q.push_back(4'd0);
        step();
        axil.s_araddr = 6'h00; axil.s_arvalid = 1'b1;
        step();
        axil.s_arvalid = 1'b0;
        step();
        @(negedge clk);
        check("t7_rvalid_pre", 32'(axil.s_rvalid), 32'd1);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("t7_ready_in_reset", 32'({axil.s_awready, axil.s_wready, axil.s_arready}), 32'd0);
        step();
        @(negedge clk);
        check("t7_rvalid_post", 32'(axil.s_rvalid), 32'd0);
        check("t7_strobes_post", 32'({reg_read, reg_write}), 32'd0);
        check("t7_rdata_post", axil.s_rdata, 32'd0);
        step();
        reset = 1'b0; axil.s_rready = 1'b1;
        step();
        @(negedge clk);
        check("t7_idle_after", 32'({axil.s_awready, axil.s_wready, axil.s_arready}), 32'd7);
        repeat (2) step();

        check("end_wr_q", 32'(wr_q.size()), 32'd0);
        check("end_rd_addr_q", 32'(rd_addr_q.size()), 32'd0);
        check("end_bresp_q", 32'(bresp_q.size()), 32'd0);
        check("end_rd_q", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_axil_bridge.md
UART_AXIL_BRIDGE -- requirements
Module: uart_axil_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning the AXI-Lite byte-address width (word index = addr[5:2]).
REQ-002 The block SHALL have parameter NUM_REGS, default 8, meaning the number of implemented word registers; higher word indices are unmapped.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_W/1/1  AXI-Lite write-address channel.
REQ-006 s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  AXI-Lite write-data channel.
REQ-007 s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  AXI-Lite write-response channel.
REQ-008 s_araddr/s_arvalid/s_arready  in/in/out  ADDR_W/1/1  AXI-Lite read-address channel.
REQ-009 s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  AXI-Lite read-data channel.
REQ-010 reg_write/reg_read  output  1/1  register-interface write and read strobes.
REQ-011 reg_addr  output  4  word address, equal to the captured addr[5:2].
REQ-012 reg_wdata  output  32  write data; reg_rdata  input  32  read data, valid combinationally while reg_read is high.
REQ-013 reg_ready  input  1  register interface accepts the strobe this cycle.

Function
REQ-014 The FSM SHALL have states IDLE, WR_EXEC, WR_RESP, RD_EXEC and RD_RESP, with one outstanding transaction at most.
REQ-015 In IDLE, s_awready SHALL equal the inverse of aw_held and s_wready SHALL equal the inverse of w_held; AW and W SHALL be captured independently, in either order or in the same cycle.
REQ-016 In IDLE, s_arready SHALL be 1 only when aw_held, w_held, s_awvalid and s_wvalid are all 0 (write has priority over a simultaneous read).
REQ-017 When both AW and W are held, the FSM SHALL enter WR_EXEC on the next cycle; with write completing in cycle N, reg_write is high in N+1.
REQ-018 In WR_EXEC the block SHALL drive reg_write=1, reg_addr and reg_wdata, hold them until a cycle with reg_ready=1, then enter WR_RESP.
REQ-019 In WR_RESP, s_bvalid SHALL be 1 with s_bresp stable until s_bready=1; it SHALL then clear both holds and return to IDLE (minimum s_bvalid at N+2).
REQ-020 An AR handshake in IDLE SHALL capture s_araddr and enter RD_EXEC.
REQ-021 RD_EXEC SHALL drive reg_read=1, register reg_rdata into s_rdata in the cycle reg_ready=1, then enter RD_RESP (s_rvalid at N+2 after AR at N).
REQ-022 In RD_RESP, s_rvalid SHALL be 1 with s_rdata/s_rresp stable until s_rready=1, then return to IDLE.
REQ-023 A word index >= NUM_REGS SHALL produce no reg strobe, a response of SLVERR (2'b10), and s_rdata=0; the EXEC state is still spent, so latency is unchanged.
REQ-024 A write with s_wstrb != 4'hF SHALL produce no reg_write and respond SLVERR; otherwise the response SHALL be OKAY (2'b00).
REQ-025 Address bits [1:0] SHALL be ignored.
REQ-026 reg_write and reg_read SHALL never be high in the same cycle, and each SHALL be high in exactly one reg_ready=1 cycle per transaction.

Reset
REQ-027 While reset is high, the state SHALL be IDLE, aw_held=w_held=0, and all of s_*ready, s_bvalid, s_rvalid, reg_write and reg_read SHALL be 0; s_bresp, s_rresp and s_rdata SHALL be 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction without a response and without a pending strobe.

Structure
REQ-029 The state enum, the AXI response constants (OKAY, SLVERR) and NUM_REGS default SHALL live in shared package uart_pkg.
REQ-030 The block SHALL be a single module with no sub-module.

Verification
REQ-031 Single write: AW+W together, addr 0x0C, data 0xA5, wstrb F -> reg_write 1 cycle later with reg_addr 3 and wdata 0xA5; bvalid after a further cycle with OKAY.
REQ-032 W at cycle 0 and AW at cycle 3 -> reg_write exactly once, in cycle 4; s_wready stays 0 for cycles 1-3.
REQ-033 Read addr 0x08 with reg_rdata=0x12345678 and rready held low 5 cycles -> rdata=0x12345678 and rvalid stable throughout; OKAY.
REQ-034 Write to 0x20 and read from 0x3C -> no strobes, SLVERR, rdata 0; write with wstrb 4'h3 to 0x04 -> SLVERR, no reg_write.
REQ-035 AW/W/AR asserted in the same cycle -> the write completes first; arready rises only after the bready handshake; the read then completes.
REQ-036 reg_ready low for 3 cycles during WR_EXEC -> reg_write held 4 cycles, single bvalid; reset asserted in RD_RESP -> rvalid 0 in the next cycle.
